// File: rtl/inst_issue_queue.sv
// Multi-lane in-order instruction queue between fetch and dual-issue decode.
// Optional macro INST_QUEUE_KEEP_DS_EN: flush_keep1 retains the delay-slot entry on flush.
module inst_issue_queue #(
   parameter int DEPTH       = 16,
   parameter int FETCH_W     = 2,
   parameter int ISSUE_W     = 2,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int AFULL_SLACK = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          flush_keep1,
   input  logic [FETCH_W-1:0]            push_valid,
   input  logic [FETCH_W*DATA_W-1:0]     push_inst,
   input  logic [FETCH_W*ADDR_W-1:0]     push_pc,
   output logic                          push_ready,
   input  logic [$clog2(ISSUE_W+1)-1:0]  pop_cnt,
   output logic [ISSUE_W-1:0]            out_valid,
   output logic [ISSUE_W*DATA_W-1:0]     out_inst,
   output logic [ISSUE_W*ADDR_W-1:0]     out_pc,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic                          empty,
   output logic                          almost_full
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int POP_W = $clog2(ISSUE_W+1);
   localparam int PSH_W = $clog2(FETCH_W+1);

   logic [DATA_W-1:0] r_inst [DEPTH];
   logic [ADDR_W-1:0] r_pc   [DEPTH];
   logic [PTR_W-1:0]  r_head, r_tail;
   logic [CNT_W-1:0]  r_count;

   logic [CNT_W:0]    w_free;
   logic [PSH_W-1:0]  w_off [FETCH_W];
   logic [PSH_W-1:0]  w_pushed;
   logic [CNT_W-1:0]  w_push_n, w_pop_req, w_popped;
   logic [PTR_W-1:0]  w_new_head;
   logic              w_keep;

   assign w_free      = (CNT_W+1)'(DEPTH) - {1'b0, r_count};
   assign push_ready  = w_free >= (CNT_W+1)'(FETCH_W);
   assign almost_full = w_free <= (CNT_W+1)'(AFULL_SLACK);
   assign empty       = (r_count == '0);
   assign count       = r_count;

   // Each valid lane lands at tail + (number of valid lanes below it), so gaps collapse.
   always_comb begin
      w_pushed = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         w_off[i] = w_pushed;
         w_pushed = w_pushed + PSH_W'(push_valid[i]);
      end
   end

   always_comb begin
      w_pop_req = (pop_cnt > POP_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : CNT_W'(pop_cnt);
      w_popped  = (w_pop_req > r_count) ? r_count : w_pop_req;
      w_push_n  = push_ready ? CNT_W'(w_pushed) : '0;
   end

   assign w_new_head = r_head + PTR_W'(w_popped);

`ifdef INST_QUEUE_KEEP_DS_EN
   assign w_keep = flush & flush_keep1 & (r_count > w_popped);
`else
   logic w_unused_keep;
   assign w_unused_keep = flush_keep1;
   assign w_keep        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         // Retained entry stays in place; the window just shrinks around it.
         if (w_keep) begin
            r_head  <= w_new_head;
            r_tail  <= w_new_head + PTR_W'(1);
            r_count <= CNT_W'(1);
         end else begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end
      end else begin
         r_head  <= w_new_head;
         r_tail  <= r_tail + PTR_W'(w_push_n);
         r_count <= r_count + w_push_n - w_popped;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && push_ready) begin
         for (int i = 0; i < FETCH_W; i++) begin
            if (push_valid[i]) begin
               r_inst[r_tail + PTR_W'(w_off[i])] <= push_inst[i*DATA_W +: DATA_W];
               r_pc[r_tail + PTR_W'(w_off[i])]   <= push_pc[i*ADDR_W +: ADDR_W];
            end
         end
      end
   end

   for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
      logic [PTR_W-1:0] w_idx;
      assign w_idx        = r_head + PTR_W'(g);
      assign out_valid[g] = CNT_W'(g) < r_count;
      assign out_inst[g*DATA_W +: DATA_W] = out_valid[g] ? r_inst[w_idx] : '0;
      assign out_pc[g*ADDR_W +: ADDR_W]   = out_valid[g] ? r_pc[w_idx]   : '0;
   end
endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue (DEPTH=16, FETCH_W=ISSUE_W=2).
module tb_inst_issue_queue;
   localparam logic [31:0] K = 32'h5A5A_5A5A;

   logic        clk = 1'b0;
   logic        rst, flush, flush_keep1, push_ready, empty, almost_full;
   logic [1:0]  push_valid, pop_cnt, out_valid;
   logic [63:0] push_inst, push_pc, out_inst, out_pc;
   logic [4:0]  count;
   int          n_vec = 0;
   int          n_miss = 0;
   logic [31:0] exp_pc [14];

   inst_issue_queue dut (
      .clk(clk), .rst(rst), .flush(flush), .flush_keep1(flush_keep1),
      .push_valid(push_valid), .push_inst(push_inst), .push_pc(push_pc),
      .push_ready(push_ready), .pop_cnt(pop_cnt), .out_valid(out_valid),
      .out_inst(out_inst), .out_pc(out_pc), .count(count), .empty(empty),
      .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push_valid  = 2'b00;
      pop_cnt     = 2'd0;
      flush       = 1'b0;
      flush_keep1 = 1'b0;
   endtask

   task automatic push(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
      push_valid = v;
      push_pc    = {pc1, pc0};
      push_inst  = {pc1 ^ K, pc0 ^ K};
   endtask

   task automatic chk_out(input string tag, input int cnt, input logic [1:0] v,
                          input logic [31:0] pc1, input logic [31:0] pc0);
      logic [31:0] e1, e0;
      e1 = v[1] ? pc1 : 32'h0;
      e0 = v[0] ? pc0 : 32'h0;
      chk({tag, ".count"}, 64'(count), 64'(cnt));
      chk({tag, ".valid"}, 64'(out_valid), 64'(v));
      chk({tag, ".pc"}, out_pc, {e1, e0});
      chk({tag, ".inst"}, out_inst, {v[1] ? pc1 ^ K : 32'h0, v[0] ? pc0 ^ K : 32'h0});
   endtask

   task automatic chk_reset(input string tag);
      chk_out(tag, 0, 2'b00, 32'h0, 32'h0);
      chk({tag, ".empty"}, 64'(empty), 64'(1));
      chk({tag, ".afull"}, 64'(almost_full), 64'(0));
      chk({tag, ".ready"}, 64'(push_ready), 64'(1));
   endtask

   initial begin
      idle();
      push(2'b00, 32'h0, 32'h0);
      rst = 1'b1;
      step();
      chk_reset("reset");
      rst = 1'b0;

      // two-lane push, then drain
      push(2'b11, 32'h1000, 32'h1004);
      step(); idle();
      chk_out("t1", 2, 2'b11, 32'h1004, 32'h1000);
      chk("t1.ready", 64'(push_ready), 64'(1));
      pop_cnt = 2'd2;
      step(); idle();
      chk_out("t1pop", 0, 2'b00, 32'h0, 32'h0);
      chk("t1pop.empty", 64'(empty), 64'(1));

      // only lane 1 valid: compacted to head
      push(2'b10, 32'hDEAD0000, 32'h2004);
      step(); idle();
      chk_out("t2", 1, 2'b01, 32'h0, 32'h2004);

      // fill towards full
      for (int k = 0; k < 6; k++) begin
         push(2'b11, 32'h3000 + 32'(8*k), 32'h3004 + 32'(8*k));
         exp_pc[2*k]   = 32'h3000 + 32'(8*k);
         exp_pc[2*k+1] = 32'h3004 + 32'(8*k);
         step();
      end
      idle();
      chk("t3.c13", 64'(count), 64'(13));
      chk("t3.af13", 64'(almost_full), 64'(1));
      push(2'b01, 32'h4000, 32'h0);
      step(); idle();
      chk("t3.c14", 64'(count), 64'(14));
      chk("t3.ready14", 64'(push_ready), 64'(1));
      chk("t3.af14", 64'(almost_full), 64'(1));
      push(2'b01, 32'h4100, 32'h0);
      step(); idle();
      chk("t3.c15", 64'(count), 64'(15));
      chk("t3.ready15", 64'(push_ready), 64'(0));
      push(2'b11, 32'h5000, 32'h5004);
      step(); idle();
      chk("t3.drop", 64'(count), 64'(15));
      pop_cnt = 2'd1;
      step(); idle();
      chk_out("t3pop", 14, 2'b11, 32'h3004, 32'h3000);
      push(2'b11, 32'h6000, 32'h6004);
      step(); idle();
      chk("t3.c16", 64'(count), 64'(16));
      chk("t3.ready16", 64'(push_ready), 64'(0));
      chk("t3.af16", 64'(almost_full), 64'(1));
      chk("t3.empty16", 64'(empty), 64'(0));

      // pop at full with a dropped push, then drain across the wrap
      push(2'b11, 32'h7000, 32'h7004);
      pop_cnt = 2'd2;
      step(); idle();
      chk_out("t4", 14, 2'b11, 32'h300C, 32'h3008);
      for (int j = 0; j < 10; j++) exp_pc[j] = exp_pc[j+2];
      exp_pc[10] = 32'h4000;
      exp_pc[11] = 32'h4100;
      exp_pc[12] = 32'h6000;
      exp_pc[13] = 32'h6004;
      for (int j = 0; j < 7; j++) begin
         chk_out("t4drain", 14 - 2*j, 2'b11, exp_pc[2*j+1], exp_pc[2*j]);
         pop_cnt = 2'd2;
         step(); idle();
      end
      chk("t4.empty", 64'(empty), 64'(1));

      // flush with delay-slot retention request
      push(2'b11, 32'hA000, 32'hA004);
      step();
      push(2'b01, 32'hA008, 32'h0);
      step(); idle();
      chk("t5.c3", 64'(count), 64'(3));
      pop_cnt = 2'd2; flush = 1'b1; flush_keep1 = 1'b1;
      push(2'b11, 32'hE000, 32'hE004);
      step(); idle();
`ifdef INST_QUEUE_KEEP_DS_EN
      chk_out("t5keep", 1, 2'b01, 32'h0, 32'hA008);
      chk("t5keep.empty", 64'(empty), 64'(0));
`else
      chk_out("t5", 0, 2'b00, 32'h0, 32'h0);
      chk("t5.empty", 64'(empty), 64'(1));
`endif
      push(2'b11, 32'hB000, 32'hB004);
      step(); idle();
      flush = 1'b1;
      push(2'b11, 32'hE008, 32'hE00C);
      step(); idle();
      chk_out("t5flush", 0, 2'b00, 32'h0, 32'h0);
      chk("t5flush.empty", 64'(empty), 64'(1));
      push(2'b11, 32'hB010, 32'hB014);
      step(); idle();
      pop_cnt = 2'd2; flush = 1'b1; flush_keep1 = 1'b1;
      step(); idle();
      chk_out("t5allpop", 0, 2'b00, 32'h0, 32'h0);

      // pop clamping and simultaneous push/pop at empty
      push(2'b01, 32'hC000, 32'h0);
      step(); idle();
      chk_out("t6", 1, 2'b01, 32'h0, 32'hC000);
      pop_cnt = 2'd2;
      step(); idle();
      chk_out("t6pop", 0, 2'b00, 32'h0, 32'h0);
      chk("t6.empty", 64'(empty), 64'(1));
      push(2'b11, 32'hD000, 32'hD004);
      pop_cnt = 2'd2;
      step(); idle();
      chk_out("t6pushpop", 2, 2'b11, 32'hD004, 32'hD000);
      push(2'b01, 32'hD008, 32'h0);
      step(); idle();
      pop_cnt = 2'd3;
      step(); idle();
      chk_out("t6pop3", 1, 2'b01, 32'h0, 32'hD008);

      // reset dominates flush/push/pop
      rst = 1'b1; flush = 1'b1; pop_cnt = 2'd1;
      push(2'b11, 32'hF000, 32'hF004);
      step();
      rst = 1'b0; idle();
      chk_reset("t6rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
